// File: rtl/gpr_file.sv
// Architectural general-purpose register file for the npc core.
// Commits execute-stage writebacks into the register array and serves two
// combinational read ports. A per-register busy scoreboard lets issue logic
// stall on read-after-write hazards while a multi-cycle producer is in flight.
module gpr_file #(
    parameter int ISA_WIDTH      = 32,
    parameter int REG_NUM        = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit BYPASS         = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [ISA_WIDTH-1:0]      src1,
    output logic [ISA_WIDTH-1:0]      src2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    input  logic                      issue_valid,
    input  logic                      issue_w_en,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [ISA_WIDTH-1:0]      wb_data,
    output logic [ISA_WIDTH-1:0]      gpr_a0
);

    // Array spans the full index space so any address is a legal subscript;
    // entries at or above REG_NUM are never written and stay zero.
    localparam int DEPTH = 2 ** REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH:0] REG_LIMIT = (REG_ADDR_WIDTH + 1)'(REG_NUM);

    logic [ISA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]     busy;
    logic                 ready_q;
    logic                 commit;
    logic                 issue_set;
    logic [DEPTH-1:0]     set_vec;
    logic [DEPTH-1:0]     clr_vec;
    logic                 hit1;
    logic                 hit2;

    // True for an index that names a real, writable register (not x0).
    function automatic logic writable(input logic [REG_ADDR_WIDTH-1:0] a);
        return (a != '0) && ({1'b0, a} < REG_LIMIT);
    endfunction

    assign wb_ready  = ready_q;
    assign commit    = wb_valid & ready_q & wb_en & writable(wb_addr);
    assign issue_set = issue_valid & issue_w_en & writable(issue_rd);
    assign set_vec   = issue_set ? (DEPTH'(1) << issue_rd) : '0;
    assign clr_vec   = commit ? (DEPTH'(1) << wb_addr) : '0;

    // Writeback is accepted from the first edge after reset release onward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_q <= 1'b0;
        else      ready_q <= 1'b1;
    end

    // Register array: commit the writeback beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard: a new producer's set overrides a retiring producer's clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= (busy & ~clr_vec) | set_vec;
    end

    // Read ports with optional same-cycle forwarding of data and busy clear.
    always_comb begin
        hit1     = (BYPASS != 1'b0) && commit && (wb_addr == rs1_addr);
        hit2     = (BYPASS != 1'b0) && commit && (wb_addr == rs2_addr);
        src1     = '0;
        src2     = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (ready_q && writable(rs1_addr)) begin
            src1     = hit1 ? wb_data : regs[rs1_addr];
            rs1_busy = busy[rs1_addr] & ~(hit1 & ~set_vec[rs1_addr]);
        end
        if (ready_q && writable(rs2_addr)) begin
            src2     = hit2 ? wb_data : regs[rs2_addr];
            rs2_busy = busy[rs2_addr] & ~(hit2 & ~set_vec[rs2_addr]);
        end
    end

    // a0 is exported raw (no forwarding) for the simulator's exit-code path.
    generate
        if (REG_NUM > 10) begin : g_a0
            assign gpr_a0 = ready_q ? regs[10] : '0;
        end else begin : g_no_a0
            assign gpr_a0 = '0;
        end
    endgenerate

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: a vector table of one-cycle stimulus with
// hand-computed expectations, plus hand-written reset and write/read sequences.
module tb_gpr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] src1, src2;
    logic        rs1_busy, rs2_busy;
    logic        issue_valid, issue_w_en;
    logic [4:0]  issue_rd;
    logic        wb_valid, wb_ready, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] gpr_a0;

    int tests = 0;
    int fails = 0;

    gpr_file dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .src1(src1), .src2(src2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_w_en(issue_w_en), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .gpr_a0(gpr_a0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wv, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv, iw;
        logic [4:0]  ir;
        logic [4:0]  r1, r2;
        logic [31:0] e1, e2;
        logic        eb1, eb2;
        logic [31:0] ea0;
    } vec_t;

    vec_t vt [21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wb_valid = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        issue_valid = 0; issue_w_en = 0; issue_rd = 0;
    endtask

    task automatic apply(input vec_t v);
        wb_valid = v.wv; wb_en = v.we; wb_addr = v.wa; wb_data = v.wd;
        issue_valid = v.iv; issue_w_en = v.iw; issue_rd = v.ir;
        rs1_addr = v.r1; rs2_addr = v.r2;
    endtask

    initial begin
        //        wv we wa     wd            iv iw ir  r1  r2  e1            e2            b1 b2 a0
        vt[0]  = '{1, 1, 5'd0, 32'hFFFFFFFF, 1, 1, 5'd0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 0, 0, 32'h0};
        vt[1]  = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        0, 0, 32'h0};
        vt[2]  = '{1, 0, 5'd7, 32'h1234,     0, 0, 5'd0, 5'd7, 5'd7, 32'h0, 32'h0,        0, 0, 32'h0};
        vt[3]  = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd7, 5'd0, 32'h0, 32'h0,        0, 0, 32'h0};
        vt[4]  = '{0, 0, 5'd0, 32'h0,        1, 1, 5'd3, 5'd0, 5'd3, 32'h0, 32'h0,        0, 0, 32'h0};
        vt[5]  = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0,        0, 1, 32'h0};
        vt[6]  = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0,        0, 1, 32'h0};
        vt[7]  = '{1, 1, 5'd3, 32'h42,       0, 0, 5'd0, 5'd3, 5'd3, 32'h42, 32'h42,      0, 0, 32'h0};
        vt[8]  = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd3, 5'd3, 32'h42, 32'h42,      0, 0, 32'h0};
        vt[9]  = '{1, 1, 5'd3, 32'h55,       1, 1, 5'd3, 5'd3, 5'd0, 32'h55, 32'h0,       0, 0, 32'h0};
        vt[10] = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd3, 5'd0, 32'h55, 32'h0,       1, 0, 32'h0};
        vt[11] = '{1, 1, 5'd3, 32'h66,       1, 1, 5'd3, 5'd3, 5'd0, 32'h66, 32'h0,       1, 0, 32'h0};
        vt[12] = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd3, 5'd0, 32'h66, 32'h0,       1, 0, 32'h0};
        vt[13] = '{1, 1, 5'd3, 32'h77,       1, 1, 5'd4, 5'd3, 5'd4, 32'h77, 32'h0,       0, 0, 32'h0};
        vt[14] = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd3, 5'd4, 32'h77, 32'h0,       0, 1, 32'h0};
        vt[15] = '{0, 0, 5'd0, 32'h0,        1, 0, 5'd6, 5'd6, 5'd0, 32'h0, 32'h0,        0, 0, 32'h0};
        vt[16] = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd6, 5'd0, 32'h0, 32'h0,        0, 0, 32'h0};
        vt[17] = '{1, 1, 5'd10, 32'h7,       0, 0, 5'd0, 5'd10, 5'd0, 32'h7, 32'h0,       0, 0, 32'h0};
        vt[18] = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd10, 5'd0, 32'h7, 32'h0,       0, 0, 32'h7};
        vt[19] = '{0, 0, 5'd0, 32'h0,        1, 1, 5'd3, 5'd3, 5'd0, 32'h77, 32'h0,       0, 0, 32'h7};
        vt[20] = '{0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd3, 5'd0, 32'h77, 32'h0,       1, 0, 32'h7};

        // Reset held for three edges.
        rst = 0; rs1_addr = 5'd5; rs2_addr = 5'd10; idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, wb_ready}, 32'h0);
        chk("rst_src1", src1, 32'h0);
        chk("rst_src2", src2, 32'h0);
        chk("rst_busy", {30'b0, rs1_busy, rs2_busy}, 32'h0);
        chk("rst_a0", gpr_a0, 32'h0);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("ready_before_edge", {31'b0, wb_ready}, 32'h0);
        @(posedge clk); #1;
        chk("ready_after_edge", {31'b0, wb_ready}, 32'h1);

        // Write then read in the same cycle (forwarded), then from the array.
        wb_valid = 1; wb_en = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        @(negedge clk);
        chk("wr_rd_bypass", src1, 32'hDEADBEEF);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("wr_rd_next", src1, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Vector table: inputs held for one cycle, outputs checked before the edge.
        for (int i = 0; i < 21; i++) begin
            apply(vt[i]);
            @(negedge clk);
            chk($sformatf("v%0d_src1", i), src1, vt[i].e1);
            chk($sformatf("v%0d_src2", i), src2, vt[i].e2);
            chk($sformatf("v%0d_rs1_busy", i), {31'b0, rs1_busy}, {31'b0, vt[i].eb1});
            chk($sformatf("v%0d_rs2_busy", i), {31'b0, rs2_busy}, {31'b0, vt[i].eb2});
            chk($sformatf("v%0d_a0", i), gpr_a0, vt[i].ea0);
            @(posedge clk); #1;
        end

        // Async reset between edges: busy[3]=1, x10=7 at this point.
        idle(); rs1_addr = 5'd3; rs2_addr = 5'd5;
        #2;
        chk("pre_async_busy", {31'b0, rs1_busy}, 32'h1);
        chk("pre_async_a0", gpr_a0, 32'h7);
        rst = 0;
        #1;
        chk("async_a0", gpr_a0, 32'h0);
        chk("async_rs1_busy", {31'b0, rs1_busy}, 32'h0);
        chk("async_src2", src2, 32'h0);
        chk("async_ready", {31'b0, wb_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'b0, wb_ready}, 32'h1);
        chk("post_rst_x5", src2, 32'h0);
        chk("post_rst_busy3", {31'b0, rs1_busy}, 32'h0);
        rs1_addr = 5'd10;
        #1;
        chk("post_rst_x10", src1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
- Architectural general-purpose register file for the npc core.
- Sits at the far end of the execute-stage writeback interface: it receives the srd / gpr_w_en pair produced by execute and commits them into the register array.
- Sources src1 / src2 for decode and execute.
- Holds a per-register pending-write scoreboard so issue logic can stall on read-after-write hazards when a producer (e.g. lw) takes more than one cycle.

Parameters:
ISA_WIDTH, 32, data width of every register.
REG_NUM, 32, number of architectural registers (16 for RV32E builds).
REG_ADDR_WIDTH, 5, register index width; must satisfy 2**REG_ADDR_WIDTH >= REG_NUM.
BYPASS, 1, 1 = same-cycle write-to-read forwarding and scoreboard clear-forwarding; 0 = none.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-low.
rs1_addr  input  REG_ADDR_WIDTH  read port 1 index.
rs2_addr  input  REG_ADDR_WIDTH  read port 2 index.
src1  output  ISA_WIDTH  read port 1 data.
src2  output  ISA_WIDTH  read port 2 data.
rs1_busy  output  1  rs1 has an outstanding writer.
rs2_busy  output  1  rs2 has an outstanding writer.
issue_valid  input  1  an instruction is issuing this cycle.
issue_w_en  input  1  issuing instruction writes a GPR.
issue_rd  input  REG_ADDR_WIDTH  destination of issuing instruction.
wb_valid  input  1  writeback beat present.
wb_ready  output  1  file accepts writeback.
wb_en  input  1  writeback actually writes (gpr_w_en from execute).
wb_addr  input  REG_ADDR_WIDTH  writeback destination.
wb_data  input  ISA_WIDTH  writeback value (srd from execute).
gpr_a0  output  ISA_WIDTH  live value of x10, used by the simulator for trap/exit code on ebreak.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers clear to 0 and all busy bits clear.
  - wb_ready=0, so src1, src2, gpr_a0, rs1_busy and rs2_busy all read 0.
  - A reset asserted mid-operation discards pending writes and the scoreboard immediately.
  - wb_ready rises on the first rising clk edge with rst=1 and stays 1 thereafter.
- Commit: at a rising edge with wb_valid & wb_ready & wb_en & wb_addr!=0 & wb_addr<REG_NUM, reg[wb_addr] <= wb_data.
  - wb_valid & wb_ready with wb_en=0 is a handshake that changes no register and no busy bit.
- x0: always reads 0, is never written, and is never marked busy.
  - Indices >= REG_NUM read 0, are ignored on write and are never busy.
- Reads are combinational (zero-latency).
  - With BYPASS=1, if a commit to the same nonzero index is occurring this cycle, srcN = wb_data; otherwise srcN = reg[rsN_addr].
  - With BYPASS=0, the new value is visible the cycle after commit.
- Scoreboard, one busy bit per register:
  - Set at an edge where issue_valid & issue_w_en & issue_rd!=0 & issue_rd<REG_NUM.
  - Cleared at an edge where a commit (as defined above) targets that index.
  - Simultaneous set and clear of the same index: set wins, since the new producer supersedes the old one.
  - Different indices update independently in the same cycle.
- rsN_busy = busy[rsN_addr] & rsN_addr!=0.
  - With BYPASS=1, it is additionally masked to 0 when this cycle's commit targets rsN_addr and the same edge is not setting that bit again.
- Ordering: the scoreboard tracks at most one outstanding writer per register. A second issue to an already-busy rd simply keeps the bit set; stalling issue in that case is the issue logic's job.
- gpr_a0 = reg[10] (registered value, no bypass); reads 0 when REG_NUM <= 10.

Test Plan:
- Reset check: rst=0 for 3 cycles, then release -> every register reads 0, wb_ready=0 during reset and 1 from the first edge after release, both busy outputs 0.
- Write then read: commit x5=0xDEADBEEF with rs1_addr=5 in the same cycle.
  - BYPASS=1 -> src1=0xDEADBEEF in that cycle.
  - BYPASS=0 -> src1=0 in that cycle, 0xDEADBEEF the next.
- x0 immunity: commit x0=0xFFFFFFFF, and issue with issue_rd=0 -> src1 (rs1_addr=0)=0 and rs1_busy=0 in all following cycles.
- wb_en gating: wb_valid=1, wb_en=0, wb_addr=7, wb_data=0x1234 -> x7 unchanged (0) and busy[7] unchanged.
- Scoreboard lifecycle:
  - Issue rd=3 -> rs2_busy=1 with rs2_addr=3 from the next cycle.
  - Commit x3=0x42 three cycles later -> rs2_busy=0 and src2=0x42 in the commit cycle (BYPASS=1).
  - Same-edge issue rd=3 plus commit x3 -> busy[3] remains 1 after the edge.
- Async reset mid-flight: busy[3]=1 and x10=0x7, pull rst low between clock edges -> gpr_a0=0 and rs1_busy=0 immediately, without waiting for a clock edge.
